// File: rtl/std_mem_copy_pkg.sv
// Shared types and helpers for the std_mem copy engine.
package std_mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } copy_state_e;

  // Pointer increment per word: bytes per word for byte addressing, else 1.
  function automatic int unsigned addr_step(input int unsigned byte_shifted,
                                            input int unsigned data_width);
    return (byte_shifted != 0) ? data_width / 8 : 1;
  endfunction

endpackage

// File: rtl/std_mem_copy_buffer.sv
// Small power-of-2 FIFO holding read results until their write is accepted.
module std_mem_copy_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/std_mem_copy_engine.sv
// std_mem initiator copying length words src->dst with credit-limited reads.
// Optional STD_MEM_COPY_FILL_EN adds fill_mode/fill_data for constant fills.
module std_mem_copy_engine
  import std_mem_copy_pkg::*;
#(
  parameter int ADDR_BYTE_SHIFTED = 0,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int LENGTH_WIDTH      = 16,
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LENGTH_WIDTH-1:0] length,
`ifdef STD_MEM_COPY_FILL_EN
  input  logic                    fill_mode,
  input  logic [DATA_WIDTH-1:0]   fill_data,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    rd_command_valid,
  input  logic                    rd_command_ready,
  output logic [ADDR_WIDTH-1:0]   rd_command_addr,
  output logic                    rd_command_read_enable,
  output logic [DATA_WIDTH/8-1:0] rd_command_write_enable,
  output logic [DATA_WIDTH-1:0]   rd_command_write_data,
  input  logic                    rd_result_valid,
  output logic                    rd_result_ready,
  input  logic [DATA_WIDTH-1:0]   rd_result_data,
  output logic                    wr_command_valid,
  input  logic                    wr_command_ready,
  output logic [ADDR_WIDTH-1:0]   wr_command_addr,
  output logic                    wr_command_read_enable,
  output logic [DATA_WIDTH/8-1:0] wr_command_write_enable,
  output logic [DATA_WIDTH-1:0]   wr_command_write_data
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(addr_step(ADDR_BYTE_SHIFTED, DATA_WIDTH));

  copy_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0]   rd_ptr, wr_ptr;
  logic [LENGTH_WIDTH-1:0] reads_left, writes_left, reads_init;
  logic [CW-1:0]           credits, buf_count;
  logic                    fill_q;
  logic [DATA_WIDTH-1:0]   fill_data_q, buf_head;
  logic                    buf_empty, buf_full;
  logic                    start_ok, rd_fire, wr_fire, buf_push, buf_pop;

  assign start_ok = (state == IDLE) && start;
  assign rd_fire  = rd_command_valid && rd_command_ready;
  assign wr_fire  = wr_command_valid && wr_command_ready;
  assign buf_push = rd_result_valid && rd_result_ready;
  // Fill writes never borrowed a read credit, so they do not touch the buffer.
  assign buf_pop  = wr_fire && !fill_q;

`ifdef STD_MEM_COPY_FILL_EN
  assign reads_init = fill_mode ? '0 : length;
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (start_ok) begin
      fill_q      <= fill_mode;
      fill_data_q <= fill_data;
    end
  end
`else
  assign reads_init  = length;
  assign fill_q      = 1'b0;
  assign fill_data_q = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (length == '0) ? DONE : RUN;
      RUN:   if (reads_left == '0) state_nxt = DRAIN;
      DRAIN: if (writes_left == '0 ||
                 (wr_fire && writes_left == LENGTH_WIDTH'(1))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      reads_left  <= '0;
      writes_left <= '0;
      credits     <= '0;
    end else begin
      if (start_ok) begin
        rd_ptr      <= src_addr;
        wr_ptr      <= dst_addr;
        reads_left  <= reads_init;
        writes_left <= length;
      end else begin
        if (rd_fire) begin
          rd_ptr     <= rd_ptr + STEP;
          reads_left <= reads_left - LENGTH_WIDTH'(1);
        end
        if (wr_fire) begin
          wr_ptr      <= wr_ptr + STEP;
          writes_left <= writes_left - LENGTH_WIDTH'(1);
        end
      end
      // A credit covers a word from read issue until its write is accepted.
      case ({rd_fire, buf_pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  std_mem_copy_buffer #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (rd_result_data),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  assign rd_command_valid        = (state == RUN) && (reads_left != '0) &&
                                   (credits < CW'(MAX_OUTSTANDING));
  assign rd_command_addr         = rd_ptr;
  assign rd_command_read_enable  = 1'b1;
  assign rd_command_write_enable = '0;
  assign rd_command_write_data   = '0;
  assign rd_result_ready         = busy;

  assign wr_command_valid        = fill_q ? (((state == RUN) || (state == DRAIN)) &&
                                             (writes_left != '0))
                                          : !buf_empty;
  assign wr_command_addr         = wr_ptr;
  assign wr_command_read_enable  = 1'b0;
  assign wr_command_write_enable = '1;
  assign wr_command_write_data   = fill_q ? fill_data_q : buf_head;

  // A result beat must belong to a read that is still in flight.
  always_ff @(posedge clk) begin
    if (!rst && rd_result_valid) begin
      assert (credits > buf_count);
    end
    if (!rst && buf_push && !buf_pop) begin
      assert (!buf_full);
    end
  end

endmodule
